// File: rtl/config_word_loader_pkg.sv
// Shared types and defaults for the config word loader.
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WORD_W    = 32;
  localparam int DEF_NUM_WORDS = 34;

  // Bit offset of word idx inside a flattened word bus.
  function automatic int word_slice(input int idx, input int word_w = DEF_WORD_W);
    return idx * word_w;
  endfunction

endpackage

// File: rtl/config_word_loader_if.sv
// Burst/commit/readback signal bundle between the deserialiser side and the loader.
interface config_word_loader_if #(
  parameter int WORD_W    = config_loader_pkg::DEF_WORD_W,
  parameter int NUM_WORDS = config_loader_pkg::DEF_NUM_WORDS
);
  localparam int ADDR_W = $clog2(NUM_WORDS);
  localparam int CNT_W  = $clog2(NUM_WORDS + 1);

  logic                        io_start;
  logic [ADDR_W-1:0]           io_base_addr;
  logic [CNT_W-1:0]            io_count;
  logic [WORD_W-1:0]           io_d_in;
  logic                        io_d_valid;
  logic                        io_d_ready;
  logic                        io_commit;
  logic [ADDR_W-1:0]           io_rd_addr;
  logic [WORD_W-1:0]           io_rd_data;
  logic                        io_busy;
  logic                        io_done;
  logic                        io_err;
  logic [WORD_W-1:0]           io_checksum;
  logic [WORD_W*NUM_WORDS-1:0] io_configs_out;

  // Requester side: drives bursts, commits and readback addresses.
  modport master (
    output io_start, io_base_addr, io_count, io_d_in, io_d_valid, io_commit, io_rd_addr,
    input  io_d_ready, io_rd_data, io_busy, io_done, io_err, io_checksum, io_configs_out
  );

  // Loader side.
  modport slave (
    input  io_start, io_base_addr, io_count, io_d_in, io_d_valid, io_commit, io_rd_addr,
    output io_d_ready, io_rd_data, io_busy, io_done, io_err, io_checksum, io_configs_out
  );

endinterface

// File: rtl/config_word_bank.sv
// Shadow bank (write port + registered read port) and active bank with bulk commit.
module config_word_bank
  import config_loader_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_wr_en,
  input  logic [ADDR_W-1:0]           i_wr_addr,
  input  logic [WORD_W-1:0]           i_wr_data,
  input  logic [ADDR_W-1:0]           i_rd_addr,
  output logic [WORD_W-1:0]           o_rd_data,
  input  logic                        i_commit,
  output logic [WORD_W*NUM_WORDS-1:0] o_active
);

  localparam logic [ADDR_W:0] LP_NUM = (ADDR_W + 1)'(NUM_WORDS);

  logic [WORD_W-1:0] r_shadow [NUM_WORDS];
  logic [WORD_W-1:0] r_active [NUM_WORDS];
  logic [WORD_W-1:0] r_rd_data;

  // Shadow write and commit copy; commit sees the shadow contents before this edge's write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (i_wr_en && (i_wr_addr == ADDR_W'(i))) begin
          r_shadow[i] <= i_wr_data;
        end
        if (i_commit) begin
          r_active[i] <= r_shadow[i];
        end
      end
    end
  end

  // Registered readback: old data on a same-cycle write, zero past the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if ({1'b0, i_rd_addr} < LP_NUM) begin
      r_rd_data <= r_shadow[i_rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign o_rd_data = r_rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_pack
      assign o_active[word_slice(gi, WORD_W) +: WORD_W] = r_active[gi];
    end
  endgenerate

endmodule

// File: rtl/config_word_loader.sv
// Burst loader: validates a request, streams words into the shadow bank with a
// running XOR checksum, and commits the shadow bank to the active bus on request.
module config_word_loader
  import config_loader_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic                clk,
  input  logic                reset,
  config_word_loader_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_WORDS);
  localparam int CNT_W  = $clog2(NUM_WORDS + 1);
  // Range sum is one bit wider than strictly needed so base+count can never wrap.
  localparam int SUM_W  = ADDR_W + 2;
  localparam logic [SUM_W-1:0] LP_LIMIT = SUM_W'(NUM_WORDS);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_remaining;
  logic [WORD_W-1:0] r_checksum;
  logic              r_err;

  logic [SUM_W-1:0]  w_end;
  logic              w_req_ok;
  logic              w_beat;
  logic              w_commit;
  logic [WORD_W-1:0] w_rd_data;
  logic [WORD_W*NUM_WORDS-1:0] w_active;

  assign w_end    = SUM_W'(bus.io_base_addr) + SUM_W'(bus.io_count);
  assign w_req_ok = (bus.io_count != '0) && (w_end <= LP_LIMIT);
  assign w_beat   = (r_state == LOAD) && bus.io_d_valid;
  assign w_commit = (r_state == IDLE) && bus.io_commit;

  // Control FSM with address/remaining counters, checksum and error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_checksum  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.io_start) begin
            if (w_req_ok) begin
              r_addr      <= bus.io_base_addr;
              r_remaining <= bus.io_count;
              r_checksum  <= '0;
              r_state     <= LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.io_commit) begin
            r_err <= 1'b1;
          end
          if (w_beat) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - CNT_W'(1);
            r_checksum  <= r_checksum ^ bus.io_d_in;
            if (r_remaining == CNT_W'(1)) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.io_commit) begin
            r_err <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  config_word_bank #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_beat),
    .i_wr_addr (r_addr),
    .i_wr_data (bus.io_d_in),
    .i_rd_addr (bus.io_rd_addr),
    .o_rd_data (w_rd_data),
    .i_commit  (w_commit),
    .o_active  (w_active)
  );

  assign bus.io_d_ready     = (r_state == LOAD);
  assign bus.io_busy        = (r_state != IDLE);
  assign bus.io_done        = (r_state == DONE);
  assign bus.io_err         = r_err;
  assign bus.io_checksum    = r_checksum;
  assign bus.io_rd_data     = w_rd_data;
  assign bus.io_configs_out = w_active;

endmodule

// File: tb/tb_config_word_loader.sv
// Self-checking bench for config_word_loader: request table, scoreboarded readback,
// hand-written sequences for reset, commit and same-cycle corner cases.
module tb_config_word_loader;

  localparam int W = 32;
  localparam int N = 34;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  config_word_loader_if #(.WORD_W(W), .NUM_WORDS(N)) vif();

  config_word_loader #(.WORD_W(W), .NUM_WORDS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_shadow [N];
  logic [31:0] m_active [N];
  logic [31:0] m_checksum;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t rd_q[$];

  typedef struct {
    int          base;
    int          cnt;
    bit          exp_err;
    logic [31:0] seed;
  } vec_t;
  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_active(input string name);
    int nbad;
    nbad = 0;
    for (int i = 0; i < N; i++) begin
      if (vif.io_configs_out[i*W +: W] !== m_active[i]) nbad++;
    end
    chk({name, "_badwords"}, 32'(nbad), 32'd0);
  endtask

  // Issue one readback: expectation queued at drive time, popped when data is due.
  task automatic rd_check(input int addr);
    rd_exp_t e;
    vif.io_rd_addr = 6'(addr);
    e.addr = addr;
    e.data = (addr < N) ? m_shadow[addr] : 32'h0;
    rd_q.push_back(e);
    tick();
    e = rd_q.pop_front();
    chk($sformatf("rd[%0d]", e.addr), vif.io_rd_data, e.data);
  endtask

  task automatic do_start(input int base, input int cnt, input bit exp_err);
    vif.io_start     = 1'b1;
    vif.io_base_addr = 6'(base);
    vif.io_count     = 6'(cnt);
    tick();
    vif.io_start = 1'b0;
    $display("start base=%0d count=%0d err=%0b busy=%0b", base, cnt, vif.io_err, vif.io_busy);
    if (exp_err) begin
      chk("start_err", 32'(vif.io_err), 32'd1);
      chk("start_err_busy", 32'(vif.io_busy), 32'd0);
      chk("start_err_cksum", vif.io_checksum, m_checksum);
      tick();
      chk("err_pulse_len", 32'(vif.io_err), 32'd0);
    end else begin
      chk("start_busy", 32'(vif.io_busy), 32'd1);
      chk("start_ready", 32'(vif.io_d_ready), 32'd1);
      chk("start_no_err", 32'(vif.io_err), 32'd0);
      m_checksum = 32'h0;
    end
  endtask

  task automatic do_load(input int base, input int cnt, input logic [31:0] seed, input bit gaps);
    int beats, cyc, dones, early;
    bit v;
    logic [31:0] d;
    beats = 0; cyc = 0; dones = 0; early = 0;
    while (beats < cnt && cyc < 2000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = seed + 32'(beats);
      vif.io_d_valid = v;
      vif.io_d_in    = v ? d : $urandom;
      tick();
      cyc++;
      if (v) begin
        m_shadow[base + beats] = d;
        m_checksum = m_checksum ^ d;
        beats++;
      end
      if (vif.io_done) begin
        dones++;
        if (beats < cnt) early++;
      end
    end
    vif.io_d_valid = 1'b0;
    $display("burst base=%0d count=%0d cycles=%0d checksum=%h", base, cnt, cyc, vif.io_checksum);
    chk("load_beats", 32'(beats), 32'(cnt));
    chk("done_once", 32'(dones), 32'd1);
    chk("done_early", 32'(early), 32'd0);
    chk("checksum", vif.io_checksum, m_checksum);
    chk("done_ready", 32'(vif.io_d_ready), 32'd0);
    chk_active("active_hold_load");
    tick();
    chk("done_len", 32'(vif.io_done), 32'd0);
    chk("idle_busy", 32'(vif.io_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;

    vecs = '{
      '{30,  5, 1'b1, 32'h0},
      '{ 0,  0, 1'b1, 32'h0},
      '{33,  1, 1'b0, 32'h1000},
      '{30,  4, 1'b0, 32'h2000},
      '{34,  1, 1'b1, 32'h0},
      '{63, 63, 1'b1, 32'h0},
      '{ 0, 35, 1'b1, 32'h0},
      '{12,  8, 1'b0, 32'h3000}
    };

    for (int i = 0; i < N; i++) begin
      m_shadow[i] = 32'h0;
      m_active[i] = 32'h0;
    end
    m_checksum = 32'h0;

    vif.io_start = 1'b0; vif.io_base_addr = '0; vif.io_count = '0;
    vif.io_d_in = '0; vif.io_d_valid = 1'b0; vif.io_commit = 1'b0; vif.io_rd_addr = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(vif.io_busy), 32'd0);
    chk("rst_ready", 32'(vif.io_d_ready), 32'd0);
    chk("rst_done", 32'(vif.io_done), 32'd0);
    chk("rst_err", 32'(vif.io_err), 32'd0);
    chk("rst_cksum", vif.io_checksum, 32'h0);
    chk_active("rst_active");
    reset = 1'b0;
    tick();

    // Reset in the middle of a burst drops it and clears the shadow bank
    do_start(0, 5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vif.io_d_valid = 1'b1;
      vif.io_d_in    = 32'hA0 + 32'(i);
      tick();
    end
    vif.io_d_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    $display("mid-load reset busy=%0b checksum=%h", vif.io_busy, vif.io_checksum);
    chk("mrst_busy", 32'(vif.io_busy), 32'd0);
    chk("mrst_ready", 32'(vif.io_d_ready), 32'd0);
    chk("mrst_done", 32'(vif.io_done), 32'd0);
    chk("mrst_err", 32'(vif.io_err), 32'd0);
    chk("mrst_cksum", vif.io_checksum, 32'h0);
    chk("mrst_rd", vif.io_rd_data, 32'h0);
    chk_active("mrst_active");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) rd_check(i);

    // Full-bank burst with random valid gaps
    do_start(0, 34, 1'b0);
    do_load(0, 34, 32'h1, 1'b1);
    chk("xor_1_34", vif.io_checksum, 32'h23);
    chk_active("pre_commit");

    // Commit copies shadow to the active bus
    vif.io_commit = 1'b1;
    tick();
    vif.io_commit = 1'b0;
    for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    $display("commit word0=%h word33=%h", vif.io_configs_out[31:0], vif.io_configs_out[1087:1056]);
    chk("commit_w0", vif.io_configs_out[31:0], 32'd1);
    chk("commit_w33", vif.io_configs_out[1087:1056], 32'd34);
    chk_active("commit_all");
    chk("commit_no_err", 32'(vif.io_err), 32'd0);

    // Request table: range/zero-count rejection and accepted bursts
    for (int k = 0; k < 8; k++) begin
      do_start(vecs[k].base, vecs[k].cnt, vecs[k].exp_err);
      if (!vecs[k].exp_err) do_load(vecs[k].base, vecs[k].cnt, vecs[k].seed, k[0]);
    end

    // Commit during LOAD is rejected and the burst still completes
    do_start(10, 3, 1'b0);
    vif.io_commit = 1'b1;
    tick();
    vif.io_commit = 1'b0;
    $display("commit in load err=%0b busy=%0b", vif.io_err, vif.io_busy);
    chk("load_commit_err", 32'(vif.io_err), 32'd1);
    chk("load_commit_busy", 32'(vif.io_busy), 32'd1);
    chk_active("load_commit_hold");
    do_load(10, 3, 32'h500, 1'b1);

    // Start and commit in the same idle cycle: commit takes the old shadow
    vif.io_commit    = 1'b1;
    vif.io_start     = 1'b1;
    vif.io_base_addr = 6'd20;
    vif.io_count     = 6'd2;
    tick();
    vif.io_commit = 1'b0;
    vif.io_start  = 1'b0;
    for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    m_checksum = 32'h0;
    $display("start+commit busy=%0b err=%0b", vif.io_busy, vif.io_err);
    chk("sc_busy", 32'(vif.io_busy), 32'd1);
    chk("sc_err", 32'(vif.io_err), 32'd0);
    chk_active("sc_active");
    do_load(20, 2, 32'h7000, 1'b0);

    // Readback: same-cycle write returns old data, then new data, out-of-range reads 0
    do_start(7, 1, 1'b0);
    old = m_shadow[7];
    vif.io_rd_addr = 6'd7;
    vif.io_d_valid = 1'b1;
    vif.io_d_in    = 32'hDEADBEEF;
    tick();
    vif.io_d_valid = 1'b0;
    m_shadow[7] = 32'hDEADBEEF;
    m_checksum  = 32'hDEADBEEF;
    $display("write addr 7 rd_data=%h done=%0b", vif.io_rd_data, vif.io_done);
    chk("rd_same_cycle_old", vif.io_rd_data, old);
    chk("rb_done", 32'(vif.io_done), 32'd1);
    chk("rb_cksum", vif.io_checksum, 32'hDEADBEEF);
    tick();
    chk("rd_after_write", vif.io_rd_data, 32'hDEADBEEF);
    rd_check(7);
    rd_check(40);
    for (int i = 0; i < N; i++) rd_check(i);

    // Final commit of everything loaded so far
    vif.io_commit = 1'b1;
    tick();
    vif.io_commit = 1'b0;
    for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    chk_active("final_commit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
